// File: rtl/data_sym_map16.sv
// data_sym_map16: bit-to-symbol mapper for a 52-subcarrier OFDM symbol.
// Upstream and downstream use a strobe/ack handshake. One output register
// gives one cycle of latency, and new words can stream at one per cycle.
// Modes: 16QAM (4 bits per word) or QPSK (2 bits per word). The mode is
// sampled only while the block is idle.
// Build option: define PILOT_INS_EN to insert pilots at subcarriers
// 6/20/31/45. Without it, every subcarrier carries data and PW_SEL is unused.
module data_sym_map16 (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic [3:0]  DAT_I,
  input  logic        WE_I,
  input  logic        STB_I,
  input  logic        CYC_I,
  output logic        ACK_O,
  input  logic        QAM,
  input  logic        QPSK,
  input  logic [1:0]  PW_SEL,
  output logic [31:0] DAT_O,
  output logic        CYC_O,
  output logic        STB_O,
  output logic        WE_O,
  input  logic        ACK_I,
  output logic [5:0]  SC_IDX
);

  localparam logic [5:0]  LAST_SC = 6'd51;
  localparam logic [15:0] QAM_HI  = 16'd3886;
  localparam logic [15:0] QAM_LO  = 16'd1295;
  localparam logic [15:0] QPSK_A  = 16'd2896;

  logic        qam_mode;
  logic [5:0]  sc_cnt;
  logic        ena;
  logic        out_halt;
  logic        pilot_slot;
  logic        idle;
  logic        load;
  logic [31:0] data_word;
  logic [31:0] pilot_word;
  logic        unused_in;

  // The mode comes from QAM alone. QPSK is only the complementary
  // indication, so it is not needed for decoding.
  assign unused_in = ^{QPSK, PW_SEL};

  // Return value (set ? +m : -m) in two's complement.
  function automatic logic [15:0] signed_mag(input logic sgn, input logic [15:0] m);
    return sgn ? m : (~m + 16'd1);
  endfunction

  assign ena      = CYC_I & STB_I & WE_I;
  assign out_halt = STB_O & ~ACK_I;
  assign idle     = ~CYC_I & ~STB_O;
  // A pilot slot loads from inside the block, so the cycle only needs
  // CYC_I. A data slot loads only when upstream is actually writing.
  assign load     = ~out_halt & CYC_I & (pilot_slot | (STB_I & WE_I));
  assign ACK_O    = ena & ~out_halt & ~pilot_slot;
  assign WE_O     = STB_O;

`ifdef PILOT_INS_EN
  logic [15:0] pilot_amp;

  assign pilot_slot = (sc_cnt == 6'd6) | (sc_cnt == 6'd20) |
                      (sc_cnt == 6'd31) | (sc_cnt == 6'd45);

  // Pilot amplitude chosen by PW_SEL.
  always_comb begin
    pilot_amp = 16'd4096;
    case (PW_SEL)
      2'd0: pilot_amp = 16'd4096;
      2'd1: pilot_amp = 16'd4092;
      2'd2: pilot_amp = 16'd529;
      2'd3: pilot_amp = 16'd194;
      default: pilot_amp = 16'd4096;
    endcase
  end

  assign pilot_word = {16'd0, signed_mag(sc_cnt != 6'd45, pilot_amp)};
`else
  assign pilot_slot = 1'b0;
  assign pilot_word = 32'd0;
`endif

  // Map the input bits to the constellation point for the latched mode.
  always_comb begin
    data_word = 32'd0;
    if (qam_mode) begin
      data_word[31:16] = signed_mag(DAT_I[2], DAT_I[3] ? QAM_HI : QAM_LO);
      data_word[15:0]  = signed_mag(DAT_I[0], DAT_I[1] ? QAM_HI : QAM_LO);
    end else begin
      data_word[31:16] = signed_mag(DAT_I[1], QPSK_A);
      data_word[15:0]  = signed_mag(DAT_I[0], QPSK_A);
    end
  end

  // Output register, subcarrier counter and mode latch.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      DAT_O    <= 32'd0;
      STB_O    <= 1'b0;
      CYC_O    <= 1'b0;
      SC_IDX   <= 6'd0;
      sc_cnt   <= 6'd0;
      qam_mode <= 1'b0;
    end else begin
      if (idle) begin
        qam_mode <= QAM;
        sc_cnt   <= 6'd0;
        CYC_O    <= 1'b0;
      end
      if (load) begin
        DAT_O  <= pilot_slot ? pilot_word : data_word;
        STB_O  <= 1'b1;
        CYC_O  <= 1'b1;
        SC_IDX <= sc_cnt;
        sc_cnt <= (sc_cnt == LAST_SC) ? 6'd0 : sc_cnt + 6'd1;
      end else if (!out_halt) begin
        STB_O <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_data_sym_map16.sv
// Testbench for data_sym_map16: randomized handshake traffic checked
// against a behavioural model and a scoreboard of accepted words.
module tb_data_sym_map16;

  logic        CLK_I = 1'b0;
  logic        RST_I;
  logic [3:0]  DAT_I;
  logic        WE_I, STB_I, CYC_I;
  logic        ACK_O;
  logic        QAM, QPSK;
  logic [1:0]  PW_SEL;
  logic [31:0] DAT_O;
  logic        CYC_O, STB_O, WE_O;
  logic        ACK_I;
  logic [5:0]  SC_IDX;

  data_sym_map16 dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .DAT_I(DAT_I), .WE_I(WE_I), .STB_I(STB_I),
    .CYC_I(CYC_I), .ACK_O(ACK_O), .QAM(QAM), .QPSK(QPSK), .PW_SEL(PW_SEL),
    .DAT_O(DAT_O), .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O), .ACK_I(ACK_I),
    .SC_IDX(SC_IDX)
  );

  always #5 CLK_I = ~CLK_I;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state: what the output port should show right now.
  logic [31:0] m_dat;
  bit          m_stb, m_cyc, m_qam, m_pil;
  int          m_sc, m_cnt;
  logic [31:0] sb_q[$];
  logic [31:0] obs_dat;
  int          amps[4] = '{4096, 4092, 529, 194};

  function automatic bit is_pilot(input int i);
`ifdef PILOT_INS_EN
    return (i == 6) || (i == 20) || (i == 31) || (i == 45);
`else
    return (i < 0);
`endif
  endfunction

  function automatic int lvl(input bit s, input bit m);
    int v;
    v = m ? 3886 : 1295;
    return s ? v : -v;
  endfunction

  function automatic logic [31:0] sym(input bit qam, input logic [3:0] d);
    int im, re;
    if (qam) begin
      im = lvl(d[2], d[3]);
      re = lvl(d[0], d[1]);
    end else begin
      im = d[1] ? 2896 : -2896;
      re = d[0] ? 2896 : -2896;
    end
    return {im[15:0], re[15:0]};
  endfunction

  function automatic logic [31:0] pil_word(input int idx, input logic [1:0] pw);
    int p;
    p = amps[pw];
    if (idx == 45) p = -p;
    return {16'd0, p[15:0]};
  endfunction

  function automatic bit exp_ack();
    bit halt;
    halt = m_stb && !ACK_I;
    return CYC_I && STB_I && WE_I && !halt && !is_pilot(m_cnt);
  endfunction

  task automatic model_reset();
    m_dat = 32'd0; m_stb = 0; m_cyc = 0; m_qam = 0; m_pil = 0;
    m_sc = 0; m_cnt = 0;
    sb_q.delete();
  endtask

  // One clock: check the DUT against the model, then advance the model.
  task automatic cycle();
    bit halt, pil, acc, ldp;
    @(negedge CLK_I);
    check_val("ack_o",  32'(ACK_O),  32'(exp_ack()));
    check_val("stb_o",  32'(STB_O),  32'(m_stb));
    check_val("we_o",   32'(WE_O),   32'(m_stb));
    check_val("cyc_o",  32'(CYC_O),  32'(m_cyc));
    check_val("sc_idx", 32'(SC_IDX), 32'(m_sc));
    check_val("dat_o",  DAT_O,       m_dat);
    obs_dat = DAT_O;
    @(posedge CLK_I);
    halt = m_stb && !ACK_I;
    pil  = is_pilot(m_cnt);
    acc  = CYC_I && STB_I && WE_I && !halt && !pil;
    ldp  = CYC_I && pil && !halt;
    if (m_stb && ACK_I && !m_pil) begin
      if (sb_q.size() == 0) check_val("sb_underflow", 32'(sb_q.size()), 32'd1);
      else check_val("sb_order", obs_dat, sb_q.pop_front());
    end
    if (!CYC_I && !m_stb) begin
      m_qam = QAM; m_cnt = 0; m_cyc = 0;
    end
    if (acc || ldp) begin
      m_dat = ldp ? pil_word(m_cnt, PW_SEL) : sym(m_qam, DAT_I);
      if (acc) sb_q.push_back(m_dat);
      m_pil = ldp; m_stb = 1; m_cyc = 1; m_sc = m_cnt;
      m_cnt = (m_cnt + 1) % 52;
    end else if (!halt) begin
      m_stb = 0;
    end
    #1;
  endtask

  task automatic drive_rand(input bit allow_idle);
    CYC_I  = allow_idle ? ($urandom_range(0, 19) != 0) : 1'b1;
    STB_I  = ($urandom_range(0, 4) != 0);
    WE_I   = ($urandom_range(0, 9) != 0);
    ACK_I  = ($urandom_range(0, 3) != 0);
    DAT_I  = 4'($urandom_range(0, 15));
    QAM    = 1'($urandom_range(0, 1));
    QPSK   = ~QAM;
    PW_SEL = 2'($urandom_range(0, 3));
  endtask

  task automatic async_reset_check(input string tag);
    RST_I = 1'b1;
    #2;
    model_reset();
    check_val({tag, "_dat"}, DAT_O,       m_dat);
    check_val({tag, "_stb"}, 32'(STB_O),  32'(m_stb));
    check_val({tag, "_cyc"}, 32'(CYC_O),  32'(m_cyc));
    check_val({tag, "_sc"},  32'(SC_IDX), 32'(m_sc));
    RST_I = 1'b0;
  endtask

  initial begin
    int guard;
    RST_I = 1'b1; DAT_I = 4'd0; WE_I = 0; STB_I = 0; CYC_I = 0;
    QAM = 1'b1; QPSK = 1'b0; PW_SEL = 2'd0; ACK_I = 1'b1;
    model_reset();
    repeat (2) @(posedge CLK_I);
    #1;
    check_val("rst_dat", DAT_O, 32'd0);
    check_val("rst_stb", 32'(STB_O), 32'd0);
    check_val("rst_cyc", 32'(CYC_O), 32'd0);
    check_val("rst_sc",  32'(SC_IDX), 32'd0);
    RST_I = 1'b0;

    // Idle cycle latches 16QAM, then one all-ones word.
    cycle();
    CYC_I = 1; STB_I = 1; WE_I = 1; DAT_I = 4'hF;
    cycle();
    check_val("qam_1111_dat", DAT_O, 32'h0F2E0F2E);
    check_val("qam_1111_stb", 32'(STB_O), 32'd1);
    check_val("qam_1111_cyc", 32'(CYC_O), 32'd1);
    check_val("qam_1111_sc",  32'(SC_IDX), 32'd0);

    // Random traffic with gaps, halts, idle drops and mode toggling.
    for (int i = 0; i < 200; i++) begin
      drive_rand(1'b1);
      cycle();
    end

    // Continuous stream at full rate, covering every slot and the wrap.
    CYC_I = 1; STB_I = 1; WE_I = 1; ACK_I = 1; PW_SEL = 2'd2;
    for (int i = 0; i < 110; i++) begin
      DAT_I = 4'($urandom_range(0, 15));
      cycle();
    end

    // Downstream stall for three cycles mid-stream.
    ACK_I = 0;
    repeat (3) cycle();
    ACK_I = 1;
    repeat (4) cycle();

    // Drain to idle, switch to QPSK, map 2'b01.
    CYC_I = 0; STB_I = 0; WE_I = 0; ACK_I = 1; QAM = 0; QPSK = 1;
    repeat (3) cycle();
    CYC_I = 1; STB_I = 1; WE_I = 1; DAT_I = 4'b0001;
    cycle();
    check_val("qpsk_01_dat", DAT_O, 32'hF4B00B50);

    // Stream until subcarrier 25 is on the output, then reset.
    guard = 0;
    while (!(m_stb && m_sc == 25) && guard < 400) begin
      drive_rand(1'b0);
      cycle();
      guard++;
    end
    check_val("reach_sc25", 32'(SC_IDX), 32'd25);
    async_reset_check("mid_rst");
    for (int i = 0; i < 120; i++) begin
      drive_rand(1'b0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
